// File: rtl/pipelined_cpu.sv
// rtl/pipelined_cpu.sv - five-stage RV32I-subset pipeline with forwarding, load-use stall and ID branch
// Defining MUL_EN adds a single-cycle mul in EX; otherwise mul decodes as a NOP.
`timescale 1ns/1ps

module pc_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_d,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

module instr_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    // Loaded externally before the core is started; the core never writes it.
    logic [31:0] memory [DEPTH];

    assign rdata = memory[addr];
endmodule

module data_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] memory [DEPTH];

    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end

    assign rdata = memory[addr];
endmodule

module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] register [32];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) register[waddr] <= wdata;
    end

    // Same-cycle write-back is visible to the ID read.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                    (we && waddr == raddr1) ? wdata : register[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                    (we && waddr == raddr2) ? wdata : register[raddr2];
endmodule

module pipelined_cpu #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [31:0] pc_o,
    output logic        stall_o,
    output logic        flush_o
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRA = 3'd5;
`ifdef MUL_EN
    localparam logic [2:0] ALU_MUL = 3'd6;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0] if_instr, rf_rdata1, rf_rdata2, dmem_rdata, wb_data;
    logic [31:0] imm_i, imm_s, imm_b, branch_target;
    logic [6:0]  id_opcode, id_f7;
    logic [2:0]  id_f3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    id_ex_t      dec;
    logic        is_beq, stall, taken;
    logic [31:0] op_a, fwd_b, alu_b, alu_result;

    pc_reg PC (
        .clk   (clk_i),
        .rst_n (rst_i),
        .pc_d  (pc_d),
        .pc_o  (pc_q)
    );

    instr_mem #(.DEPTH(IMEM_DEPTH)) Instruction_Memory (
        .addr  (pc_q[IAW+1:2]),
        .rdata (if_instr)
    );

    reg_file Registers (
        .clk    (clk_i),
        .we     (mem_wb_q.reg_write),
        .waddr  (mem_wb_q.rd),
        .wdata  (wb_data),
        .raddr1 (id_rs1),
        .raddr2 (id_rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    data_mem #(.DEPTH(DMEM_DEPTH)) Data_Memory (
        .clk   (clk_i),
        .we    (ex_mem_q.mem_write),
        .addr  (ex_mem_q.alu_result[DAW+1:2]),
        .wdata (ex_mem_q.store_data),
        .rdata (dmem_rdata)
    );

    assign id_opcode = if_id_q.instr[6:0];
    assign id_rd     = if_id_q.instr[11:7];
    assign id_f3     = if_id_q.instr[14:12];
    assign id_rs1    = if_id_q.instr[19:15];
    assign id_rs2    = if_id_q.instr[24:20];
    assign id_f7     = if_id_q.instr[31:25];

    assign imm_i = {{20{if_id_q.instr[31]}}, if_id_q.instr[31:20]};
    assign imm_s = {{20{if_id_q.instr[31]}}, if_id_q.instr[31:25], if_id_q.instr[11:7]};
    assign imm_b = {{19{if_id_q.instr[31]}}, if_id_q.instr[31], if_id_q.instr[7],
                    if_id_q.instr[30:25], if_id_q.instr[11:8], 1'b0};
    assign branch_target = if_id_q.pc + imm_b;

    always_comb begin
        dec         = '0;
        dec.rs1     = id_rs1;
        dec.rs2     = id_rs2;
        dec.rd      = id_rd;
        dec.rs1_val = rf_rdata1;
        dec.rs2_val = rf_rdata2;
        is_beq      = 1'b0;
        case (id_opcode)
            7'b0110011: begin
                dec.reg_write = 1'b1;
                case ({id_f7, id_f3})
                    10'b0000000_000: dec.alu_op = ALU_ADD;
                    10'b0100000_000: dec.alu_op = ALU_SUB;
                    10'b0000000_111: dec.alu_op = ALU_AND;
                    10'b0000000_100: dec.alu_op = ALU_XOR;
                    10'b0000000_001: dec.alu_op = ALU_SLL;
`ifdef MUL_EN
                    10'b0000001_000: dec.alu_op = ALU_MUL;
`endif
                    default:         dec.reg_write = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec.alu_src = 1'b1;
                dec.imm     = imm_i;
                if (id_f3 == 3'b000) begin
                    dec.reg_write = 1'b1;
                end else if (id_f3 == 3'b101 && id_f7 == 7'b0100000) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_SRA;
                end
            end
            7'b0000011: begin
                if (id_f3 == 3'b010) begin
                    dec.alu_src    = 1'b1;
                    dec.imm        = imm_i;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                end
            end
            7'b0100011: begin
                if (id_f3 == 3'b010) begin
                    dec.alu_src   = 1'b1;
                    dec.imm       = imm_s;
                    dec.mem_write = 1'b1;
                end
            end
            7'b1100011: is_beq = (id_f3 == 3'b000);
            default: ;
        endcase
    end

    // A load-use stall wins over a branch in ID; the branch is retried next cycle.
    assign stall = id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                   ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2));
    assign taken = is_beq && (rf_rdata1 == rf_rdata2) && !stall;

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        id_ex_d = dec;
        if (stall) begin
            id_ex_d = '0;
        end else if (taken) begin
            pc_d    = branch_target;
            if_id_d = '0;
        end else if (start_i) begin
            pc_d          = pc_q + 32'd4;
            if_id_d.pc    = pc_q;
            if_id_d.instr = if_instr;
        end else begin
            if_id_d = '0;
        end
    end

    always_comb begin
        if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1)
            op_a = ex_mem_q.alu_result;
        else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1)
            op_a = wb_data;
        else
            op_a = id_ex_q.rs1_val;

        if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2)
            fwd_b = ex_mem_q.alu_result;
        else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2)
            fwd_b = wb_data;
        else
            fwd_b = id_ex_q.rs2_val;
    end

    assign alu_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;

    always_comb begin
        alu_result = op_a + alu_b;
        case (id_ex_q.alu_op)
            ALU_SUB: alu_result = op_a - alu_b;
            ALU_AND: alu_result = op_a & alu_b;
            ALU_XOR: alu_result = op_a ^ alu_b;
            ALU_SLL: alu_result = op_a << alu_b[4:0];
            ALU_SRA: alu_result = $signed(op_a) >>> alu_b[4:0];
`ifdef MUL_EN
            ALU_MUL: alu_result = op_a * alu_b;
`endif
            default: ;
        endcase
    end

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = alu_result;
        ex_mem_d.store_data = fwd_b;
        ex_mem_d.rd         = id_ex_q.rd;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;

        mem_wb_d            = '0;
        mem_wb_d.read_data  = dmem_rdata;
        mem_wb_d.alu_result = ex_mem_q.alu_result;
        mem_wb_d.rd         = ex_mem_q.rd;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    end

    assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_result;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign pc_o    = pc_q;
    assign stall_o = stall;
    assign flush_o = taken;
endmodule

// File: tb/tb_pipelined_cpu.sv
// tb/tb_pipelined_cpu.sv - self-checking bench for pipelined_cpu
`timescale 1ns/1ps

module tb_pipelined_cpu;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_o;
    logic        stall_o;
    logic        flush_o;

    pipelined_cpu dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .pc_o    (pc_o),
        .stall_o (stall_o),
        .flush_o (flush_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;

    int n_vec = 0;
    int n_bad = 0;
    int stall_cnt, flush_cnt;
    logic [31:0] pc_hist[$];
    logic        stall_hist[$];
    logic        flush_hist[$];

    typedef struct {
        string       name;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        int          rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void expect_reg(input string name, input int r, input logic [31:0] v);
        sb_q.push_back('{name, 1'b0, r, v});
    endfunction

    function automatic void expect_mem(input string name, input int w, input logic [31:0] v);
        sb_q.push_back('{name, 1'b1, w, v});
    endfunction

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.is_mem) check(e.name, dut.Data_Memory.memory[e.idx], e.exp);
            else          check(e.name, dut.Registers.register[e.idx], e.exp);
        end
    endtask

    // Holds the core in reset and loads a clean program image.
    task automatic boot(input logic [31:0] prog[$]);
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = '0;
        for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = '0;
        for (int i = 0; i < 32; i++) dut.Registers.register[i] = '0;
        foreach (prog[i]) dut.Instruction_Memory.memory[i] = prog[i];
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        stall_cnt = 0;
        flush_cnt = 0;
        pc_hist.delete();
        stall_hist.delete();
        flush_hist.delete();
        rst_i   = 1'b1;
        start_i = 1'b1;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            pc_hist.push_back(pc_o);
            stall_hist.push_back(stall_o);
            flush_hist.push_back(flush_o);
            if (stall_o) stall_cnt++;
            if (flush_o) flush_cnt++;
        end
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [31:0] mul_exp;
        logic [31:0] tgt_pc;
        int          both;

`ifdef MUL_EN
        mul_exp = 32'd42;
`else
        mul_exp = 32'hDEADBEEF;
`endif
        vecs[0]  = '{"add",      enc_r(7'b0000000, 2, 1, 3'b000, 3), 32'd5, 32'd3, 3, 32'd8};
        vecs[1]  = '{"sub_neg",  enc_r(7'b0100000, 2, 1, 3'b000, 3), 32'd3, 32'd5, 3, 32'hFFFFFFFE};
        vecs[2]  = '{"and",      enc_r(7'b0000000, 2, 1, 3'b111, 3), 32'hF0F0F0F0, 32'hFF00FF00, 3, 32'hF000F000};
        vecs[3]  = '{"xor",      enc_r(7'b0000000, 2, 1, 3'b100, 3), 32'hF0F0F0F0, 32'hFF00FF00, 3, 32'h0FF00FF0};
        vecs[4]  = '{"sll_mask", enc_r(7'b0000000, 2, 1, 3'b001, 3), 32'd1, 32'd35, 3, 32'd8};
        vecs[5]  = '{"addi_neg", enc_i(-1, 1, 3'b000, 3, OP_I), 32'd0, 32'd0, 3, 32'hFFFFFFFF};
        vecs[6]  = '{"addi_wrap", enc_i(1, 1, 3'b000, 3, OP_I), 32'h7FFFFFFF, 32'd0, 3, 32'h80000000};
        vecs[7]  = '{"srai",     enc_i(32'h404, 1, 3'b101, 3, OP_I), 32'h80000000, 32'd0, 3, 32'hF8000000};
        vecs[8]  = '{"mul",      enc_r(7'b0000001, 2, 1, 3'b000, 3), 32'd7, 32'd6, 3, mul_exp};
        vecs[9]  = '{"bad_op",   {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1111111}, 32'd7, 32'd6, 3, 32'hDEADBEEF};
        vecs[10] = '{"x0_write", enc_r(7'b0000000, 2, 1, 3'b000, 0), 32'd9, 32'd9, 0, 32'd0};

        // Reset state and free-running fetch over an all-zero program.
        prog = {};
        boot(prog);
        start_i = 1'b1;
        #1;
        check("reset_pc", pc_o, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_flush", {31'd0, flush_o}, 32'd0);
        run(5);
        foreach (pc_hist[i]) check($sformatf("pc_step%0d", i), pc_hist[i], 32'(4 * (i + 1)));
        check("zero_prog_stalls_flushes", 32'(stall_cnt + flush_cnt), 32'd0);
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("pc_hold_start_low", pc_o, 32'd20);

        foreach (vecs[v]) begin
            prog = {vecs[v].instr};
            boot(prog);
            dut.Registers.register[1] = vecs[v].a;
            dut.Registers.register[2] = vecs[v].b;
            dut.Registers.register[3] = 32'hDEADBEEF;
            expect_reg(vecs[v].name, vecs[v].rd, vecs[v].exp);
            run(8);
            drain();
        end

        // Back-to-back dependencies resolved by forwarding.
        prog = {enc_i(5, 0, 3'b000, 1, OP_I), enc_i(3, 0, 3'b000, 2, OP_I),
                enc_r(7'b0100000, 2, 1, 3'b000, 3), enc_r(7'b0000000, 2, 1, 3'b100, 4)};
        boot(prog);
        expect_reg("fwd_sub", 3, 32'd2);
        expect_reg("fwd_xor", 4, 32'd6);
        run(12);
        drain();
        check("fwd_no_stall", stall_cnt, 32'd0);

        // Load-use: one bubble, PC one word behind free-run.
        prog = {enc_i(0, 0, 3'b010, 1, OP_LW), enc_r(7'b0000000, 1, 1, 3'b000, 2)};
        boot(prog);
        dut.Data_Memory.memory[0] = 32'd5;
        expect_reg("loaduse_add", 2, 32'd10);
        run(10);
        drain();
        check("loaduse_stall_cnt", stall_cnt, 32'd1);
        check("loaduse_pc", pc_o, 32'd36);

        // Arithmetic shift then register-amount shift.
        prog = {enc_i(-8, 0, 3'b000, 1, OP_I), enc_i(32'h401, 1, 3'b101, 2, OP_I),
                enc_r(7'b0000000, 2, 2, 3'b001, 3)};
        boot(prog);
        expect_reg("srai_fwd", 2, 32'hFFFFFFFC);
        expect_reg("sll_fwd", 3, 32'hC0000000);
        run(12);
        drain();

        // Store with forwarded data, then load it back.
        prog = {enc_i(7, 0, 3'b000, 5, OP_I), enc_s(8, 5, 0), enc_i(8, 0, 3'b010, 6, OP_LW)};
        boot(prog);
        expect_mem("sw_mem8", 2, 32'd7);
        expect_reg("lw_after_sw", 6, 32'd7);
        run(12);
        drain();
        check("sw_lw_no_stall", stall_cnt, 32'd0);

        // Taken beq at 0x08 to 0x10 squashes the fall-through addi.
        prog = {32'd0, 32'd0, enc_b(8, 0, 0), enc_i(1, 0, 3'b000, 7, OP_I),
                enc_i(2, 0, 3'b000, 8, OP_I)};
        boot(prog);
        expect_reg("taken_slot_x7", 7, 32'd0);
        expect_reg("taken_target_x8", 8, 32'd2);
        run(12);
        drain();
        check("taken_flush_cnt", flush_cnt, 32'd1);
        tgt_pc = 'x;
        for (int i = 0; i + 1 < flush_hist.size(); i++)
            if (flush_hist[i]) tgt_pc = pc_hist[i + 1];
        check("taken_target_pc", tgt_pc, 32'd16);

        // Not-taken beq leaves the fall-through path alone.
        prog = {enc_i(1, 0, 3'b000, 1, OP_I), 32'd0, 32'd0, 32'd0, enc_b(8, 1, 0),
                enc_i(1, 0, 3'b000, 7, OP_I), enc_i(2, 0, 3'b000, 8, OP_I)};
        boot(prog);
        expect_reg("nt_x7", 7, 32'd1);
        expect_reg("nt_x8", 8, 32'd2);
        run(14);
        drain();
        check("nt_flush_cnt", flush_cnt, 32'd0);

        // beq depending on a load: stall first, branch resolves the next cycle.
        prog = {enc_i(0, 0, 3'b010, 1, OP_LW), enc_b(8, 1, 0), enc_i(1, 0, 3'b000, 7, OP_I),
                enc_i(2, 0, 3'b000, 8, OP_I)};
        boot(prog);
        expect_reg("prio_slot_x7", 7, 32'd0);
        expect_reg("prio_target_x8", 8, 32'd2);
        run(12);
        drain();
        both = 0;
        foreach (stall_hist[i]) if (stall_hist[i] && flush_hist[i]) both++;
        check("prio_stall_cnt", stall_cnt, 32'd1);
        check("prio_flush_cnt", flush_cnt, 32'd1);
        check("prio_no_overlap", both, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
